// File: rtl/id_hazard_ctrl_pkg.sv
// Shared decode-stage types for the hazard controller: register address,
// producer latency class and the mul/div ownership states.
package cpu_defs;
  typedef logic [4:0] RegAddr_t;

  localparam int MAX_LAT = 3;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef logic [CNT_W-1:0] LatClass_t;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } MuldivState_t;

  localparam LatClass_t LAT_ALU  = CNT_W'(0);
  localparam LatClass_t LAT_LOAD = CNT_W'(1);
endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Decode <-> interlock bundle: decode drives the instruction fields and flush,
// the controller answers with stall/issue and HI/LO ownership.
interface id_hazard_ctrl_if;
  import cpu_defs::*;

  logic      id_valid;
  RegAddr_t  id_raddr1;
  RegAddr_t  id_raddr2;
  logic      id_we;
  RegAddr_t  id_waddr;
  LatClass_t id_lat;
  logic      id_muldiv;
  logic      id_hilo_use;
  logic      flush;
  logic      id_stall;
  logic      id_issue;
  logic      muldiv_busy;

  modport master (
    output id_valid, id_raddr1, id_raddr2, id_we, id_waddr, id_lat,
           id_muldiv, id_hilo_use, flush,
    input  id_stall, id_issue, muldiv_busy
  );

  modport slave (
    input  id_valid, id_raddr1, id_raddr2, id_we, id_waddr, id_lat,
           id_muldiv, id_hilo_use, flush,
    output id_stall, id_issue, muldiv_busy
  );
endinterface

// File: rtl/id_hazard_ctrl_sb_entry.sv
// One scoreboard slot: cycles remaining before a consumer of this register
// may issue. Clear beats load, load beats the per-cycle decrement.
module sb_entry
  import cpu_defs::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr,
  input  logic      load,
  input  LatClass_t load_val,
  output LatClass_t cnt
);

  // Countdown register with flush clear and issue-time load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != {CNT_W{1'b0}}) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode interlock: 31-entry register scoreboard plus HI/LO ownership FSM.
// Define ID_HAZARD_PERF_EN to add the stall_cycles / hilo_stall_cycles counters.
module id_hazard_ctrl
  import cpu_defs::*;
#(
  parameter int MULDIV_LAT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  id_hazard_ctrl_if.slave  bus
`ifdef ID_HAZARD_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      hilo_stall_cycles
`endif
);

  localparam int MD_W = $clog2(MULDIV_LAT);
  localparam logic [0:0] ST_IDLE = MD_IDLE;
  localparam logic [0:0] ST_BUSY = MD_BUSY;

  LatClass_t        cnt_s [32];
  logic [0:0]       md_state_r;
  logic [0:0]       md_state_s;
  logic [MD_W-1:0]  md_cnt_r;
  logic [MD_W-1:0]  md_cnt_s;
  logic             haz1_s;
  logic             haz2_s;
  logic             hilo_haz_s;
  logic             stall_s;
  logic             issue_s;
  logic             track_s;

  // $0 is hardwired, so its slot never holds a pending write
  assign cnt_s[0] = {CNT_W{1'b0}};

  for (genvar r = 1; r < 32; r++) begin : g_sb
    sb_entry u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (bus.flush),
      .load     (track_s && (bus.id_waddr == RegAddr_t'(r))),
      .load_val (bus.id_lat),
      .cnt      (cnt_s[r])
    );
  end

  // Interlock decision from registered state; sources read the pre-load counts
  always_comb begin
    haz1_s     = (bus.id_raddr1 != 5'd0) && (cnt_s[bus.id_raddr1] != {CNT_W{1'b0}});
    haz2_s     = (bus.id_raddr2 != 5'd0) && (cnt_s[bus.id_raddr2] != {CNT_W{1'b0}});
    hilo_haz_s = (bus.id_hilo_use || bus.id_muldiv) && (md_state_r == ST_BUSY);
    stall_s    = bus.id_valid && (haz1_s || haz2_s || hilo_haz_s);
    issue_s    = bus.id_valid && !stall_s && !bus.flush;
    track_s    = issue_s && bus.id_we && (bus.id_waddr != 5'd0);
  end

  assign bus.id_stall    = stall_s;
  assign bus.id_issue    = issue_s;
  assign bus.muldiv_busy = (md_state_r == ST_BUSY);

  // Mul/div ownership next state; flush deliberately has no effect here
  always_comb begin
    md_state_s = md_state_r;
    md_cnt_s   = md_cnt_r;
    case (md_state_r)
      ST_IDLE: begin
        if (issue_s && bus.id_muldiv) begin
          md_state_s = ST_BUSY;
          md_cnt_s   = MD_W'(MULDIV_LAT - 1);
        end else begin
          md_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (md_cnt_r == {MD_W{1'b0}}) begin
          md_state_s = ST_IDLE;
        end else begin
          md_cnt_s = md_cnt_r - MD_W'(1);
        end
      end
      default: begin
        md_state_s = ST_IDLE;
        md_cnt_s   = {MD_W{1'b0}};
      end
    endcase
  end

  // Mul/div ownership state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_state_r <= ST_IDLE;
      md_cnt_r   <= {MD_W{1'b0}};
    end else begin
      md_state_r <= md_state_s;
      md_cnt_r   <= md_cnt_s;
    end
  end

`ifdef ID_HAZARD_PERF_EN
  // Free-running (wrapping) stall statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles      <= 32'd0;
      hilo_stall_cycles <= 32'd0;
    end else begin
      if (stall_s) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (bus.id_valid && hilo_haz_s) begin
        hilo_stall_cycles <= hilo_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed table, multi-cycle HI/LO and
// reset sequences, then random traffic against an absolute-time reference model.
module tb_id_hazard_ctrl;
  import cpu_defs::*;

  localparam int MDL = 32;

  typedef struct {
    logic      v;
    RegAddr_t  r1;
    RegAddr_t  r2;
    logic      we;
    RegAddr_t  wa;
    LatClass_t lat;
    logic      md;
    logic      hilo;
    logic      fl;
    logic      s;
    logic      i;
    logic      b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl_if bus ();

`ifdef ID_HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] hilo_stall_cycles;
`endif

  id_hazard_ctrl #(.MULDIV_LAT(MDL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ID_HAZARD_PERF_EN
    ,
    .stall_cycles      (stall_cycles),
    .hilo_stall_cycles (hilo_stall_cycles)
`endif
  );

  function automatic vec_t mk(input int v, input int r1, input int r2, input int we,
                              input int wa, input int lat, input int md, input int hilo,
                              input int fl, input int s, input int i, input int b);
    vec_t t;
    t.v = 1'(v);   t.r1 = 5'(r1);  t.r2 = 5'(r2);    t.we = 1'(we);
    t.wa = 5'(wa); t.lat = CNT_W'(lat); t.md = 1'(md); t.hilo = 1'(hilo);
    t.fl = 1'(fl); t.s = 1'(s);    t.i = 1'(i);      t.b = 1'(b);
    return t;
  endfunction

  task automatic drive(input vec_t t);
    bus.id_valid    = t.v;
    bus.id_raddr1   = t.r1;
    bus.id_raddr2   = t.r2;
    bus.id_we       = t.we;
    bus.id_waddr    = t.wa;
    bus.id_lat      = t.lat;
    bus.id_muldiv   = t.md;
    bus.id_hilo_use = t.hilo;
    bus.flush       = t.fl;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk3(input string name, input logic s, input logic i, input logic b);
    chk({name, ".stall"}, bus.id_stall, s);
    chk({name, ".issue"}, bus.id_issue, i);
    chk({name, ".busy"}, bus.muldiv_busy, b);
  endtask

  task automatic step(input string name, input vec_t t);
    drive(t);
    @(negedge clk);
    chk3(name, t.s, t.i, t.b);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  int   ready_at [32];
  int   md_free_at;
  int   cyc;
  int   stall_cnt;

  initial begin
    // v r1 r2 we wa lat md hilo fl | stall issue busy
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); // reset: nothing pending
    tbl.push_back(mk(1, 1, 0, 1, 5, 1, 0, 0, 0, 0, 1, 0)); // LW r5
    tbl.push_back(mk(1, 5, 5, 1, 6, 0, 0, 0, 0, 1, 0, 0)); // ADDU r6,r5,r5 stalls
    tbl.push_back(mk(1, 5, 5, 1, 6, 0, 0, 0, 0, 0, 1, 0)); // then issues
    tbl.push_back(mk(1, 0, 0, 1, 0, 2, 0, 0, 0, 0, 1, 0)); // ADDI r0 lat 2
    tbl.push_back(mk(1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 1, 0)); // OR r7,r0,r0
    tbl.push_back(mk(1, 0, 0, 1, 3, 3, 0, 0, 0, 0, 1, 0)); // LW r3 lat 3
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // flush
    tbl.push_back(mk(1, 3, 3, 1, 8, 0, 0, 0, 0, 0, 1, 0)); // reader of r3 free
    tbl.push_back(mk(1, 0, 0, 1, 4, 1, 0, 0, 0, 0, 1, 0)); // r4 lat 1
    tbl.push_back(mk(1, 0, 0, 1, 4, 3, 0, 0, 0, 0, 1, 0)); // r4 lat 3 overrides
    tbl.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 9, 2, 0, 0, 0, 0, 1, 0)); // LW r9 lat 2
    tbl.push_back(mk(1, 9, 0, 1, 9, 1, 0, 0, 0, 1, 0, 0)); // self-dependent
    tbl.push_back(mk(1, 9, 0, 1, 9, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 9, 0, 1, 9, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); // sees the new load
    tbl.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    reset_pulse();
    for (int k = 0; k < tbl.size(); k++) begin
      step($sformatf("tbl%0d", k), tbl[k]);
    end

    // MULT, then MFLO waits out the full HI/LO ownership window (flush mid-way)
    step("mult", mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    for (int k = 1; k <= MDL; k++) begin
      step($sformatf("mflo_wait%0d", k), mk(1, 0, 0, 1, 2, 0, 0, 1, (k == 16) ? 1 : 0, 1, 0, 1));
    end
    step("madd_after_busy", mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0));
    step("lw_r10", mk(1, 0, 0, 1, 10, 3, 0, 0, 0, 0, 1, 1));

    // Asynchronous reset in the middle of a BUSY window
    drive(mk(1, 10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    #1;
    chk3("pre_rst", 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk3("in_rst", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("mfhi_after_rst", mk(1, 10, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));

    // Random traffic against an absolute-time model
    reset_pulse();
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    md_free_at = 0;
    cyc        = 0;
    stall_cnt  = 0;
    for (int n = 0; n < 600; n++) begin
      logic e_busy, e_stall, e_issue, haz;
      vec_t t;
      t = mk($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, MAX_LAT),
             $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 15) == 0, 0, 0, 0);
      drive(t);
      @(negedge clk);
      e_busy  = (cyc < md_free_at);
      haz     = ((t.r1 != 5'd0) && (cyc < ready_at[t.r1])) ||
                ((t.r2 != 5'd0) && (cyc < ready_at[t.r2])) ||
                ((t.md || t.hilo) && e_busy);
      e_stall = t.v && haz;
      e_issue = t.v && !haz && !t.fl;
      chk3($sformatf("rnd%0d", n), e_stall, e_issue, e_busy);
      if (e_stall) stall_cnt++;
      if (t.fl) begin
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
      end
      if (e_issue && t.we && (t.wa != 5'd0)) ready_at[t.wa] = cyc + 1 + int'(t.lat);
      if (e_issue && t.md) md_free_at = cyc + 1 + MDL;
      @(posedge clk);
      #1;
      cyc++;
    end
`ifdef ID_HAZARD_PERF_EN
    n_vec++;
    if (stall_cycles !== 32'(stall_cnt)) begin
      n_bad++;
      $display("FAIL stall_cycles: got %0d expected %0d", stall_cycles, stall_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
